fetch_queue_stage: RTL and testbench

Parametrised next-generation fetch stage. Generates the PC, issues fetch addresses to the instruction cache, and handles misses with a refill handshake. Buffers fetched instructions in a QUEUE_DEPTH-entry circular queue, decoupling cache latency from decode back-pressure. Sits between the icache/refill controller and the decode stage, and replaces the single pipeline register with a valid/ready queue that is flushed on redirect.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_queue.sv | 41 ++++
 rtl/fetch_queue_stage.sv | 77 +++++++
 tb/tb_fetch_queue_stage.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage and its queue.
package fetch_pkg;
    localparam int INSTR_BYTES = 4;
    localparam int ADDR_W = 64;
    localparam int INSTR_W = 32;
    typedef enum logic {FETCH, MISS_WAIT} fetch_state_t;
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetch entries with synchronous flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  entry_t        data_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [PW:0]   count_o,
    output entry_t        head_o
);
    entry_t mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   cnt_q;
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PW'(1);
            if (pop_i) rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
        end
    end
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wptr_q] <= data_i;
    end
    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign head_o  = mem_q[rptr_q];
endmodule

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: PC generation, icache miss/refill FSM and decoupling queue to decode.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCH_BYPASS_EN.
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                           i_clk,
    input  logic                           i_arst,
    input  logic                           i_pc_src,
    input  logic [ADDR_WIDTH-1:0]          i_pc_target,
    output logic [ADDR_WIDTH-1:0]          o_fetch_addr,
    input  logic                           i_icache_hit,
    input  logic [INSTR_WIDTH-1:0]         i_icache_instr,
    output logic                           o_miss,
    input  logic                           i_refill_done,
    output logic                           o_valid,
    input  logic                           i_dec_ready,
    output logic [INSTR_WIDTH-1:0]         o_instruction,
    output logic [ADDR_WIDTH-1:0]          o_pc,
    output logic [ADDR_WIDTH-1:0]          o_pc_plus4,
    output logic [$clog2(QUEUE_DEPTH):0]   o_queue_count
);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;
    fetch_state_t state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic full, empty, hit_fetch, byp, byp_take, pop, push, push_ok;
    entry_t head;
    assign hit_fetch = (state_q == FETCH) && i_icache_hit && !i_pc_src;
`ifdef FETCH_BYPASS_EN
    assign byp = empty && hit_fetch;
`else
    assign byp = 1'b0;
`endif
    assign o_valid  = !i_pc_src && (!empty || byp);
    assign pop      = !i_pc_src && !empty && i_dec_ready;
    assign byp_take = byp && i_dec_ready;
    // A full queue still accepts a push when decode drains an entry in the same cycle.
    assign push_ok  = !full || pop;
    assign push     = hit_fetch && push_ok && !byp_take;
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else if (i_pc_src) begin
            state_q <= FETCH;
            pc_q    <= {i_pc_target[ADDR_WIDTH-1:2], 2'b00};
        end else begin
            state_q <= (state_q == FETCH) ? (i_icache_hit ? FETCH : MISS_WAIT)
                                          : (i_refill_done ? FETCH : MISS_WAIT);
            if (push || byp_take) pc_q <= pc_q + ADDR_WIDTH'(INSTR_BYTES);
        end
    end
    fetch_queue #(.DEPTH(QUEUE_DEPTH), .entry_t(entry_t)) u_queue (
        .clk     (i_clk),
        .rst     (i_arst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (i_pc_src),
        .data_i  ('{pc: pc_q, instr: i_icache_instr}),
        .full_o  (full),
        .empty_o (empty),
        .count_o (o_queue_count),
        .head_o  (head)
    );
    assign o_fetch_addr  = pc_q;
    assign o_miss        = state_q == MISS_WAIT;
    assign o_instruction = byp ? i_icache_instr : head.instr;
    assign o_pc          = byp ? pc_q : head.pc;
    assign o_pc_plus4    = o_pc + ADDR_WIDTH'(INSTR_BYTES);
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage: directed vector table plus random stimulus against a queue-based reference model.
module tb_fetch_queue_stage;
    localparam int AW = 64, IW = 32, D = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0, rst, src, hit, refill, ready, miss, valid;
    logic [AW-1:0] tgt, fa, pc, pc4;
    logic [IW-1:0] instr_in, instr;
    logic [$clog2(D):0] cnt;
    fetch_queue_stage #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .QUEUE_DEPTH(D), .RESET_PC('0)) dut (
        .i_clk(clk), .i_arst(rst), .i_pc_src(src), .i_pc_target(tgt), .o_fetch_addr(fa),
        .i_icache_hit(hit), .i_icache_instr(instr_in), .o_miss(miss), .i_refill_done(refill),
        .o_valid(valid), .i_dec_ready(ready), .o_instruction(instr), .o_pc(pc),
        .o_pc_plus4(pc4), .o_queue_count(cnt)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } ent_t;
    typedef struct {
        bit rst, src, hit, refill, ready;
        logic [AW-1:0] tgt, fa, pc;
        bit miss, valid;
        int cnt;
    } vec_t;
    ent_t q[$];
    logic [AW-1:0] m_pc;
    bit m_miss;
    int n_chk = 0, n_fail = 0;
    function automatic logic [IW-1:0] mk_instr(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ a[31:0] ^ a[63:32];
    endfunction
    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask
    // One clock: drive inputs, compare outputs against the model before the edge, then advance the model.
    task automatic cycle(input bit r, input bit s, input logic [AW-1:0] t, input bit h,
                         input bit rf, input bit rd, input bit cmp);
        bit byp, pop, ev;
        @(negedge clk);
        rst = r; src = s; tgt = t; hit = h; refill = rf; ready = rd; instr_in = mk_instr(m_pc);
        #1;
        byp = BYP && q.size() == 0 && h && !m_miss && !s;
        ev = !s && (q.size() > 0 || byp);
        if (cmp) begin
            check("model fetch_addr", fa, m_pc);
            check("model miss", AW'(miss), AW'(m_miss));
            check("model count", AW'(cnt), AW'(q.size()));
            check("model valid", AW'(valid), AW'(ev));
            if (ev) begin
                check("model pc", pc, byp ? m_pc : q[0].pc);
                check("model instr", AW'(instr), AW'(byp ? mk_instr(m_pc) : q[0].instr));
                check("model pc_plus4", pc4, (byp ? m_pc : q[0].pc) + 64'd4);
            end
        end
        if (r) begin
            q.delete(); m_pc = '0; m_miss = 0;
        end else if (s) begin
            q.delete(); m_pc = {t[AW-1:2], 2'b00}; m_miss = 0;
        end else begin
            pop = ev && rd && !byp;
            if (m_miss) m_miss = !rf;
            else if (!h) m_miss = 1;
            else if (byp && rd) m_pc += 4;
            else if (q.size() < D || pop) begin
                q.push_back('{m_pc, mk_instr(m_pc)});
                m_pc += 4;
                if (pop) void'(q.pop_front());
                pop = 0;
            end
            if (pop) void'(q.pop_front());
        end
    endtask
    function automatic vec_t v(input bit r, s, input logic [AW-1:0] t, input bit h, rf, rd,
                               input logic [AW-1:0] efa, input bit em, ev, input int ec,
                               input logic [AW-1:0] epc);
        return '{rst: r, src: s, tgt: t, hit: h, refill: rf, ready: rd,
                 fa: efa, miss: em, valid: ev, cnt: ec, pc: epc};
    endfunction
    initial begin
        vec_t tv[$];
        rst = 1; src = 0; tgt = '0; hit = 0; refill = 0; ready = 0; instr_in = '0;
        m_pc = '0; m_miss = 0;
        cycle(1, 0, '0, 0, 0, 0, 0);
        cycle(1, 0, '0, 0, 0, 0, 0);
`ifndef FETCH_BYPASS_EN
        tv.push_back(v(0,0,'0,1,0,1, 64'h0,    0,0,0, '0));
        tv.push_back(v(0,0,'0,1,0,1, 64'h4,    0,1,1, 64'h0));
        tv.push_back(v(0,0,'0,1,0,1, 64'h8,    0,1,1, 64'h4));
        tv.push_back(v(0,0,'0,1,0,0, 64'hC,    0,1,1, 64'h8));
        tv.push_back(v(0,0,'0,1,0,0, 64'h10,   0,1,2, 64'h8));
        tv.push_back(v(0,0,'0,1,0,0, 64'h14,   0,1,3, 64'h8));
        tv.push_back(v(0,0,'0,1,0,0, 64'h18,   0,1,4, 64'h8));
        tv.push_back(v(0,0,'0,1,0,1, 64'h18,   0,1,4, 64'h8));
        tv.push_back(v(0,0,'0,0,0,1, 64'h1C,   0,1,4, 64'hC));
        tv.push_back(v(0,0,'0,0,0,1, 64'h1C,   1,1,3, 64'h10));
        tv.push_back(v(0,0,'0,0,0,0, 64'h1C,   1,1,2, 64'h14));
        tv.push_back(v(0,0,'0,0,1,0, 64'h1C,   1,1,2, 64'h14));
        tv.push_back(v(0,1,64'h1003,1,0,1, 64'h1C, 0,0,2, '0));
        tv.push_back(v(0,0,'0,0,0,1, 64'h1000, 0,0,0, '0));
        tv.push_back(v(0,1,64'h2000,0,0,0, 64'h1000, 1,0,0, '0));
        tv.push_back(v(0,0,'0,1,1,0, 64'h2000, 0,0,0, '0));
        tv.push_back(v(0,0,'0,0,0,0, 64'h2004, 0,1,1, 64'h2000));
        tv.push_back(v(1,0,'0,0,0,0, 64'h2004, 1,1,1, 64'h2000));
        tv.push_back(v(0,0,'0,1,1,1, 64'h0,    0,0,0, '0));
        tv.push_back(v(0,0,'0,0,0,1, 64'h4,    0,1,1, 64'h0));
        tv.push_back(v(0,1,'1,0,0,0, 64'h4,    1,0,0, '0));
        tv.push_back(v(0,0,'0,1,0,0, 64'hFFFF_FFFF_FFFF_FFFC, 0,0,0, '0));
        tv.push_back(v(0,0,'0,0,0,0, 64'h0,    0,1,1, 64'hFFFF_FFFF_FFFF_FFFC));
`else
        tv.push_back(v(0,0,'0,1,0,1, 64'h0,    0,1,0, 64'h0));
        tv.push_back(v(0,0,'0,1,0,0, 64'h4,    0,1,0, 64'h4));
        tv.push_back(v(0,0,'0,0,0,1, 64'h8,    0,1,1, 64'h4));
`endif
        foreach (tv[i]) begin
            cycle(tv[i].rst, tv[i].src, tv[i].tgt, tv[i].hit, tv[i].refill, tv[i].ready, 1);
            check($sformatf("vec%0d fetch_addr", i), fa, tv[i].fa);
            check($sformatf("vec%0d miss", i), AW'(miss), AW'(tv[i].miss));
            check($sformatf("vec%0d valid", i), AW'(valid), AW'(tv[i].valid));
            check($sformatf("vec%0d count", i), AW'(cnt), AW'(tv[i].cnt));
            if (tv[i].valid) begin
                check($sformatf("vec%0d pc", i), pc, tv[i].pc);
                check($sformatf("vec%0d pc_plus4", i), pc4, tv[i].pc + 64'd4);
            end
        end
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] t;
            t = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, 24'hFFFFFF, 8'($urandom)}
                                            : {32'h0, $urandom};
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, t,
                  $urandom_range(0, 3) != 0,
                  m_miss ? $urandom_range(0, 3) == 0 : $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1, 1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
